// File: rtl/spike_rb_pkg.sv
// Shared types for the spike readback controller: FSM states, FIFO depth and the
// per-word tag that travels with each collector read.
package spike_rb_pkg;

    localparam int FIFO_DEPTH = 3;
    // Tag fields are sized for the widest supported configuration and cast at use.
    localparam int TAG_TS_W   = 32;
    localparam int TAG_ROW_W  = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic [TAG_TS_W-1:0]  timestep;
        logic [TAG_ROW_W-1:0] row;
        logic                 last;
    } tag_t;

endpackage

// File: rtl/spike_readback_ctrl_if.sv
// Collector read port plus host output stream. out_* transfers a word on any edge where
// out_valid && out_ready; while out_valid && !out_ready the payload and tags hold steady.
interface spike_readback_ctrl_if #(
    parameter int PE_COUNT       = 128,
    parameter int TIMESTEP_WIDTH = 16,
    parameter int AW             = 16,
    parameter int ROW_W          = 8
);
    logic                      col_rd_en;
    logic [AW-1:0]             col_rd_addr;
    logic [PE_COUNT-1:0]       col_rd_data;
    logic                      out_valid;
    logic                      out_ready;
    logic [PE_COUNT-1:0]       out_data;
    logic [TIMESTEP_WIDTH-1:0] out_timestep;
    logic [ROW_W-1:0]          out_row;
    logic                      out_last;

    modport master (
        output col_rd_en, col_rd_addr, out_valid, out_data, out_timestep, out_row, out_last,
        input  col_rd_data, out_ready
    );

    modport slave (
        input  col_rd_en, col_rd_addr, out_valid, out_data, out_timestep, out_row, out_last,
        output col_rd_data, out_ready
    );
endinterface

// File: rtl/spike_rb_fifo.sv
// Three-entry synchronous FIFO holding {data, tag}; flush drops contents, reset also clears storage.
module spike_rb_fifo
    import spike_rb_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic         i_flush,
    input  logic [W-1:0] i_data,
    output logic [W-1:0] o_head,
    output logic [1:0]   o_count
);
    logic [W-1:0] r_mem [FIFO_DEPTH];
    logic [1:0]   r_wr, r_rd, r_count;
    logic         w_do_pop, w_do_push;

    assign w_do_pop  = i_pop && (r_count != 2'd0);
    assign w_do_push = i_push && ((r_count != 2'(FIFO_DEPTH)) || w_do_pop);
    assign o_head    = r_mem[r_rd];
    assign o_count   = r_count;

    function automatic logic [1:0] ptr_next(input logic [1:0] p);
        return (p == 2'(FIFO_DEPTH - 1)) ? 2'd0 : p + 2'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr] <= i_data;
                r_wr        <= ptr_next(r_wr);
            end
            if (w_do_pop) r_rd <= ptr_next(r_rd);
            r_count <= r_count + 2'(w_do_push) - 2'(w_do_pop);
        end
    end
endmodule

// File: rtl/spike_readback_ctrl.sv
// Drains the spike collector buffer to the host stream at one tagged vector per cycle,
// issuing reads ahead of the collector's 1-cycle latency into a small FIFO.
module spike_readback_ctrl
    import spike_rb_pkg::*;
#(
    parameter int  ROWS           = 256,
    parameter int  PE_COUNT       = 128,
    parameter int  TIMESTEP_WIDTH = 16,
    parameter int  MAX_TIMESTEPS  = 256,
    localparam int AW             = $clog2(MAX_TIMESTEPS * ROWS),
    localparam int ROW_W          = $clog2(ROWS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_start,
    input  logic                      i_abort,
    input  logic [TIMESTEP_WIDTH-1:0] i_num_timesteps,
    input  logic                      i_skip_zero,
    spike_readback_ctrl_if.master     bus,
    output logic                      o_collect_inhibit,
    output logic                      o_busy,
    output logic                      o_done,
    output logic [AW:0]               o_words_sent,
    output state_t                    o_dbg_state
);
    localparam int EW = PE_COUNT + $bits(tag_t);

    state_t                    r_state, w_next;
    logic [TIMESTEP_WIDTH-1:0] w_limit, r_ts;
    logic [ROW_W-1:0]          r_row;
    logic [AW-1:0]             r_addr, r_last_addr;
    logic                      r_skip_zero, r_inflight;
    tag_t                      r_inf_tag;
    logic [AW:0]               r_words_sent;

    logic                      w_issue, w_abort_now, w_push, w_pop, w_final;
    logic [1:0]                w_count;
    logic [2:0]                w_committed;
    logic [EW-1:0]             w_fifo_head;
    logic [PE_COUNT-1:0]       w_head_data;
    tag_t                      w_head_tag;

    assign w_limit     = (i_num_timesteps > TIMESTEP_WIDTH'(MAX_TIMESTEPS))
                         ? TIMESTEP_WIDTH'(MAX_TIMESTEPS) : i_num_timesteps;
    assign w_final     = (r_addr == r_last_addr);
    assign w_committed = 3'(w_count) + 3'(r_inflight);
    assign w_pop       = bus.out_valid && bus.out_ready;
    // The final word is always kept so the host always sees out_last.
    assign w_push      = r_inflight && !w_abort_now &&
                         !(r_skip_zero && (bus.col_rd_data == '0) && !r_inf_tag.last);

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        w_issue     = 1'b0;
        w_abort_now = 1'b0;
        case (r_state)
            IDLE: if (i_start) w_next = (w_limit == '0) ? DONE : ISSUE;
            ISSUE: begin
                if (i_abort) begin
                    w_abort_now = 1'b1;
                    w_next      = DONE;
                end else if (w_committed <= 3'd2) begin
                    w_issue = 1'b1;
                    if (w_final) w_next = FLUSH;
                end
            end
            FLUSH: begin
                if (i_abort) begin
                    w_abort_now = 1'b1;
                    w_next      = DONE;
                end else if (!r_inflight && ((w_count == 2'd0) || (w_count == 2'd1 && w_pop))) begin
                    w_next = DONE;
                end
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ts         <= '0;
            r_row        <= '0;
            r_addr       <= '0;
            r_last_addr  <= '0;
            r_skip_zero  <= 1'b0;
            r_inflight   <= 1'b0;
            r_inf_tag    <= '0;
            r_words_sent <= '0;
        end else if (r_state == IDLE && i_start) begin
            r_ts         <= '0;
            r_row        <= '0;
            r_addr       <= '0;
            r_last_addr  <= AW'(int'(w_limit) * ROWS - 1);
            r_skip_zero  <= i_skip_zero;
            r_inflight   <= 1'b0;
            r_words_sent <= '0;
        end else begin
            r_inflight <= w_issue;
            if (w_pop) r_words_sent <= r_words_sent + 1'b1;
            if (w_issue) begin
                r_inf_tag <= '{timestep: TAG_TS_W'(r_ts), row: TAG_ROW_W'(r_row), last: w_final};
                r_addr    <= r_addr + 1'b1;
                if (r_row == ROW_W'(ROWS - 1)) begin
                    r_row <= '0;
                    r_ts  <= r_ts + 1'b1;
                end else begin
                    r_row <= r_row + 1'b1;
                end
            end
        end
    end

    spike_rb_fifo #(.W(EW)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (w_abort_now),
        .i_data  ({bus.col_rd_data, r_inf_tag}),
        .o_head  (w_fifo_head),
        .o_count (w_count)
    );

    assign {w_head_data, w_head_tag} = w_fifo_head;

    assign bus.col_rd_en    = w_issue;
    assign bus.col_rd_addr  = r_addr;
    assign bus.out_valid    = (w_count != 2'd0);
    assign bus.out_data     = w_head_data;
    assign bus.out_timestep = TIMESTEP_WIDTH'(w_head_tag.timestep);
    assign bus.out_row      = ROW_W'(w_head_tag.row);
    assign bus.out_last     = w_head_tag.last;

    assign o_busy            = (r_state != IDLE);
    assign o_collect_inhibit = (r_state != IDLE);
    assign o_done            = (r_state == DONE);
    assign o_words_sent      = r_words_sent;
    assign o_dbg_state       = r_state;
endmodule

// File: tb/tb_spike_readback_ctrl.sv
// Bench for spike_readback_ctrl: table of drains plus abort and mid-drain reset sequences,
// with a registered collector model and an expected-word queue.
`timescale 1ns/1ps
module tb_spike_readback_ctrl;
  import spike_rb_pkg::*;

  localparam int ROWS   = 4;
  localparam int PE     = 16;
  localparam int TSW    = 16;
  localparam int MAXT   = 4;
  localparam int AW     = $clog2(MAXT * ROWS);
  localparam int ROW_W  = $clog2(ROWS);
  localparam int NWORDS = MAXT * ROWS;
  localparam int EXP_W  = PE + TSW + ROW_W + 1;

  typedef struct {
    int nts;
    bit skip;
    int mode;
    int pat;
    int exp_words;
    int exp_lat;
  } vec_t;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           i_start = 1'b0;
  logic           i_abort = 1'b0;
  logic           i_skip_zero = 1'b0;
  logic [TSW-1:0] i_num_timesteps = '0;
  logic           o_collect_inhibit, o_busy, o_done;
  logic [AW:0]    o_words_sent;
  state_t         o_dbg_state;

  spike_readback_ctrl_if #(.PE_COUNT(PE), .TIMESTEP_WIDTH(TSW), .AW(AW), .ROW_W(ROW_W)) bus ();

  spike_readback_ctrl #(
    .ROWS(ROWS), .PE_COUNT(PE), .TIMESTEP_WIDTH(TSW), .MAX_TIMESTEPS(MAXT)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .i_start           (i_start),
    .i_abort           (i_abort),
    .i_num_timesteps   (i_num_timesteps),
    .i_skip_zero       (i_skip_zero),
    .bus               (bus),
    .o_collect_inhibit (o_collect_inhibit),
    .o_busy            (o_busy),
    .o_done            (o_done),
    .o_words_sent      (o_words_sent),
    .o_dbg_state       (o_dbg_state)
  );

  // ---------------- clock / collector model ----------------
  always #5 clk = ~clk;

  logic [PE-1:0] mem [NWORDS];

  always @(posedge clk) begin
    if (bus.col_rd_en) bus.col_rd_data <= mem[bus.col_rd_addr];
  end

  // ---------------- scoreboard state ----------------
  logic [EXP_W-1:0] exp_q[$];
  int n_total = 0;
  int n_bad = 0;
  int exp_addr = 0;
  int n_issued = 0;
  int n_hs = 0;
  bit chk_commit = 1'b0;
  int ready_mode = 0;
  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name, input logic [63:0] act);
    n_total++;
    n_bad++;
    $display("FAIL %s: got %0h (t=%0t)", name, act, $time);
  endtask

  // out_ready: 0 = held high, 1 = random, other = held low
  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (ready_mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = 1'($urandom_range(0, 1));
        default: bus.out_ready = 1'b0;
      endcase
    end
  end

  // ---------------- monitor ----------------
  logic             prev_stall = 1'b0;
  logic [EXP_W-1:0] prev_word = '0;

  always @(negedge clk) begin
    logic [EXP_W-1:0] w;
    w = {bus.out_data, bus.out_timestep, bus.out_row, bus.out_last};
    if (prev_stall) check("stall_hold", {bus.out_valid, w}, {1'b1, prev_word});
    if (bus.out_valid && bus.out_ready) n_hs++;
    if (bus.col_rd_en) begin
      n_issued++;
      check("rd_addr", bus.col_rd_addr, exp_addr);
      exp_addr++;
      if (chk_commit) check("committed_le3", (n_issued - n_hs) <= 3, 1);
    end
    if (bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) fail_now("extra_word", w);
      else check("out_word", w, exp_q.pop_front());
    end
    prev_stall = bus.out_valid && !bus.out_ready && !i_abort && !rst;
    prev_word  = w;
  end

  // ---------------- driver tasks ----------------
  task automatic fill_mem(input int pat);
    for (int i = 0; i < NWORDS; i++) begin
      case (pat)
        0:       mem[i] = PE'(16'hA000 + i);
        1:       mem[i] = '0;
        2:       mem[i] = PE'($urandom_range(1, 65535));
        default: mem[i] = '0;
      endcase
    end
    if (pat == 1) begin
      mem[2] = 16'h0055;
      mem[7] = 16'h0AA0;
    end
  endtask

  task automatic prep_and_start(input int nts, input bit skip, input int mode);
    int limit, last_a;
    limit  = (nts > MAXT) ? MAXT : nts;
    last_a = limit * ROWS - 1;
    exp_q.delete();
    for (int a = 0; a < limit * ROWS; a++)
      if (!(skip && mem[a] == '0 && a != last_a))
        exp_q.push_back({mem[a], TSW'(a / ROWS), ROW_W'(a % ROWS), (a == last_a)});
    exp_addr        = 0;
    n_issued        = 0;
    n_hs            = 0;
    chk_commit      = !skip;
    ready_mode      = mode;
    i_num_timesteps = TSW'(nts);
    i_skip_zero     = skip;
    i_start         = 1'b1;
    @(posedge clk);
    #1 i_start = 1'b0;
  endtask

  task automatic run_drain(input int nts, input bit skip, input int mode,
                           input int exp_words, input int exp_lat);
    int limit;
    bit seen;
    limit = (nts > MAXT) ? MAXT : nts;
    prep_and_start(nts, skip, mode);
    seen = 1'b0;
    for (int k = 1; k <= 300 && !seen; k++) begin
      @(negedge clk);
      if (k == 1 && limit > 0) check("first_rd_en", bus.col_rd_en, 1);
      if (o_done) begin
        seen = 1'b1;
        if (exp_lat >= 0) check("done_latency", k, exp_lat);
      end
    end
    if (!seen) fail_now("done_timeout", o_dbg_state);
    check("words_sent", o_words_sent, exp_words);
    check("exp_q_drained", exp_q.size(), 0);
    check("reads_issued", n_issued, limit * ROWS);
    @(negedge clk);
    check("done_one_cycle", {o_done, o_busy, o_collect_inhibit}, 3'b000);
    check("back_to_idle", o_dbg_state, IDLE);
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ctrl"}, {o_busy, o_done, o_collect_inhibit, bus.out_valid, bus.col_rd_en}, 5'b0);
    check({tag, "_addr"}, bus.col_rd_addr, 0);
    check({tag, "_words"}, o_words_sent, 0);
    check({tag, "_payload"}, {bus.out_data, bus.out_timestep, bus.out_row, bus.out_last}, 0);
    check({tag, "_state"}, o_dbg_state, IDLE);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    vecs[0] = '{nts: 2,        skip: 1'b0, mode: 0, pat: 0, exp_words: 8,  exp_lat: 11};
    vecs[1] = '{nts: 0,        skip: 1'b0, mode: 0, pat: 0, exp_words: 0,  exp_lat: 1};
    vecs[2] = '{nts: MAXT + 5, skip: 1'b0, mode: 0, pat: 2, exp_words: 16, exp_lat: 19};
    vecs[3] = '{nts: 3,        skip: 1'b1, mode: 0, pat: 1, exp_words: 3,  exp_lat: -1};
    vecs[4] = '{nts: 4,        skip: 1'b0, mode: 1, pat: 2, exp_words: 16, exp_lat: -1};
    vecs[5] = '{nts: 1,        skip: 1'b1, mode: 0, pat: 3, exp_words: 1,  exp_lat: 7};

    fill_mem(0);
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      fill_mem(vecs[i].pat);
      run_drain(vecs[i].nts, vecs[i].skip, vecs[i].mode, vecs[i].exp_words, vecs[i].exp_lat);
    end

    // Abort with two words queued and the host stalled; a start mid-drain must be ignored.
    fill_mem(0);
    prep_and_start(4, 1'b0, 2);
    @(posedge clk);
    #1 i_start = 1'b1;
    @(posedge clk);
    #1 i_start = 1'b0;
    @(posedge clk);
    #1 i_abort = 1'b1;
    @(negedge clk);
    check("abort_pre_valid", bus.out_valid, 1);
    @(posedge clk);
    #1 i_abort = 1'b0;
    @(negedge clk);
    check("abort_valid_low", bus.out_valid, 0);
    check("abort_done", {o_done, o_busy}, 2'b11);
    check("abort_state", o_dbg_state, DONE);
    @(negedge clk);
    check("abort_end", {o_done, o_busy}, 2'b00);
    check("abort_idle", o_dbg_state, IDLE);
    check("abort_words", o_words_sent, 0);
    check("abort_reads", n_issued, 3);
    repeat (3) @(negedge clk);
    check("start_ignored", {o_busy, n_issued[3:0]}, {1'b0, 4'd3});
    exp_q.delete();
    @(posedge clk);
    #1;

    // Reset mid-drain, then a fresh drain from address 0.
    fill_mem(2);
    prep_and_start(4, 1'b0, 0);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("midreset");
    exp_q.delete();
    @(posedge clk);
    #1;
    fill_mem(0);
    run_drain(2, 1'b0, 0, 8, 11);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
    $fatal(1);
  end

endmodule

// File: doc/spike_readback_ctrl.md
# spike_readback_ctrl

Host-side drain controller for the output spike collector buffer. After a run, it sequences reads over the buffer region for `num_timesteps × ROWS` entries, compensates for the collector's 1-cycle registered read latency, and streams tagged spike vectors to the host over a ready/valid interface at one word per cycle. It sits between the collector's host read port and the host link. It optionally drops all-zero rows, and it holds off collection while draining.

## Interface
Parameters:
- `ROWS`, 256: rows per timestep; must match the collector.
- `PE_COUNT`, 128: spike vector width.
- `TIMESTEP_WIDTH`, 16: timestep field width.
- `MAX_TIMESTEPS`, 256: buffer depth in timesteps.
- `AW`, derived, `$clog2(MAX_TIMESTEPS*ROWS)`: buffer address width.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: clock.
- `rst` in 1: synchronous active-high reset.
- `start` in 1: begin a drain; sampled only in IDLE.
- `abort` in 1: terminate the drain immediately.
- `num_timesteps` in TIMESTEP_WIDTH: timesteps to drain; sampled with `start`.
- `skip_zero` in 1: drop all-zero vectors; sampled with `start`.
- `col_rd_en` out 1: read strobe to the collector.
- `col_rd_addr` out AW: collector read address.
- `col_rd_data` in PE_COUNT: collector data, valid the cycle after `col_rd_en`.
- `collect_inhibit` out 1: high while not IDLE; forces the collector's collect enable low.
- `out_valid` out 1, `out_ready` in 1: output handshake.
- `out_data` out PE_COUNT: spike vector.
- `out_timestep` out TIMESTEP_WIDTH, `out_row` out `$clog2(ROWS)`: tag of `out_data`.
- `out_last` out 1: marks the word at the final address.
- `busy` out 1: state is not IDLE.
- `done` out 1: single-cycle pulse at completion or abort.
- `words_sent` out AW+1: handshakes completed in the current or most recent drain.

## Operation
- **FSM states:**
  - IDLE: `start` latches the config, clears `words_sent` and all counters, and moves to ISSUE.
  - ISSUE: issues reads; moves to FLUSH the cycle after the final address is issued.
  - FLUSH: waits until the in-flight read has returned and the FIFO is empty, then moves to DONE.
  - DONE: asserts `done` for one cycle and returns to IDLE.
- **Limit:** `limit = min(num_timesteps, MAX_TIMESTEPS)`.
  - `limit == 0`: go `start` → DONE directly; no reads are issued and no words are emitted.
- **Addressing:**
  - `col_rd_addr = ts*ROWS + row`.
  - `row` increments from 0 to ROWS-1, then wraps to 0 and increments `ts`.
  - The final address is `(limit-1)*ROWS + ROWS-1`.
- **Issue rule:** `col_rd_en` is asserted in ISSUE when `fifo_count + inflight ≤ 2` (FIFO depth 3, `inflight` is 0 or 1). At most one read is issued per cycle.
- **Tags:** the `{ts, row, last}` tag is carried in a 1-stage register alongside the read. It is written into the FIFO together with `col_rd_data`.
- **skip_zero = 1:** an all-zero vector is discarded instead of pushed, except that the final-address word is always pushed so that `out_last` is always emitted.
- **Output:** the output presents the FIFO head. A pop occurs on `out_valid && out_ready`, and each pop increments `words_sent`.
- **Start:** `start` is ignored while `busy`.
- **Abort:** `abort` in any non-IDLE state:
  - on the next edge: FIFO flushed, returned read data dropped, `out_valid` low, state DONE;
  - the following cycle: `done` pulses and the state returns to IDLE.
  - `words_sent` keeps its count.
  - `abort` in IDLE is ignored.
- **Reset:** `rst` at any time, including mid-drain, returns to IDLE. The in-flight read is discarded.

## Timing
- **Reset values:** every output is 0; state is IDLE.
- **Start latency:** `start` sampled at edge T gives first `col_rd_en` in cycle T+1, `col_rd_data` in T+2, FIFO write at the end of T+2, and `out_valid` in T+3.
- **Throughput:** with `out_ready` held high, one word per cycle with no bubbles.
- **Backpressure:** under backpressure, `out_data` and the tags stay stable while `out_valid && !out_ready`. Reads stop once 3 words are committed (FIFO plus in-flight).
- **Completion:** `done` pulses the cycle after the last handshake; `busy` falls together with that pulse.
- **Back-to-back drains:** `start` is accepted in the cycle after `done`.

## Structure
- **Package `spike_rb_pkg`:**
  - state enum: IDLE, ISSUE, FLUSH, DONE;
  - `FIFO_DEPTH = 3`;
  - tag struct `{timestep, row, last}`.
- **Sub-module `spike_rb_fifo`:**
  - 3-entry synchronous FIFO of `{data, tag}`;
  - exposes `count`, `push`, `pop`, `flush`;
  - synchronous active-high reset.
- The FSM, counters and issue logic live in the top level.

## Test plan
- **Basic drain:** ROWS=4, `num_timesteps=2`, `out_ready=1`, `skip_zero=0`.
  - 8 words; addresses 0..7 in order; tags (0,0)…(1,3).
  - `out_last` on word 8; `words_sent=8`; `done` at T+11.
- **Backpressure:** toggle `out_ready` 1-0-0-1 randomly.
  - No loss or duplication of words.
  - `out_data` stable while stalled.
  - No more than 3 words committed at any time.
- **Zero skip:** `skip_zero=1`, only buffer entries 2 and 7 nonzero, final entry zero.
  - Emits entries 2, 7 and the final entry with `out_last`; `words_sent=3`.
- **Limits:**
  - `num_timesteps=0`: `done` at T+1 with no `col_rd_en`.
  - `num_timesteps=MAX_TIMESTEPS+5`: drain clamped to MAX_TIMESTEPS.
- **Abort mid-drain:** `abort` with 2 words in the FIFO.
  - `out_valid` low at the next edge; `done` pulses one cycle later; state IDLE.
  - A `start` issued during the drain was ignored.
- **Reset mid-drain:** `rst` mid-drain.
  - All outputs 0 next cycle.
  - A new drain from address 0 completes correctly.
